// File: rtl/csoc_uart_rx_pkg.sv
// Shared types and helpers for the CSoC UART receiver: FSM state encoding,
// default oversampling ratio, tick divider formula and the 3-sample vote.
package csoc_uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned DefOversample = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csoc_uart_rx_baud_tick.sv
// Oversample tick divider: counts 0..Div-1 and pulses tick_o for one cycle at
// the wrap. restart_i forces the count back to 0 so a frame starts phase-aligned.
module csoc_uart_rx_baud_tick #(
    parameter int unsigned Div = 14
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LastCnt);

    // Next count: restart wins over wrap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Divider state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/csoc_uart_rx.sv
// CSoC UART receiver: 2-FF rx synchroniser, 3-sample majority vote, framing
// FSM and a valid/ready holding register with framing/parity/overrun pulses.
// Build option CSOC_UART_PARITY_EN adds an even parity bit before the stop bit.
module csoc_uart_rx
    import csoc_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = DefOversample
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned TickDiv = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SmpW    = $clog2(OVERSAMPLE);
    localparam logic [SmpW-1:0] SmpA    = SmpW'(OVERSAMPLE / 2 - 1);
    localparam logic [SmpW-1:0] SmpB    = SmpW'(OVERSAMPLE / 2);
    localparam logic [SmpW-1:0] SmpC    = SmpW'(OVERSAMPLE / 2 + 1);
    localparam logic [SmpW-1:0] SmpLast = SmpW'(OVERSAMPLE - 1);

    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            tick, start_fall, vote_tick, vote, stop_perr;
    logic [SmpW-1:0] smp_q;
    logic            s0_q, s1_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    rx_state_e       state_q;
    logic [7:0]      data_q;
    logic            valid_q, ferr_q, perr_q, ovr_q;

    // Synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_fall = (state_q == StIdle) && rx_prev_q && !rx_s_q;

    csoc_uart_rx_baud_tick #(
        .Div (TickDiv)
    ) u_baud_tick (
        .clk_i     (clk),
        .rst_ni    (rstn),
        .restart_i (start_fall),
        .tick_o    (tick)
    );

    // The third mid-bit sample is taken live; the decision is made on that tick.
    assign vote_tick = tick && (smp_q == SmpC);
    assign vote      = maj3(s0_q, s1_q, rx_s_q);

    // Tick position within the current bit and the first two mid-bit samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_q <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
        end else if (state_q == StIdle) begin
            smp_q <= '0;
        end else if (tick) begin
            smp_q <= (smp_q == SmpLast) ? '0 : smp_q + 1'b1;
            if (smp_q == SmpA) s0_q <= rx_s_q;
            if (smp_q == SmpB) s1_q <= rx_s_q;
        end
    end

`ifdef CSOC_UART_PARITY_EN
    logic par_err_q;
    assign stop_perr = par_err_q;

    // Even parity over data and parity bit, voted at parity mid-bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else if (start_fall) begin
            par_err_q <= 1'b0;
        end else if (state_q == StParity && vote_tick) begin
            par_err_q <= ^{shift_q, vote};
        end
    end
`else
    assign stop_perr = 1'b0;
`endif

    // Framing FSM with registered holding register and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_fall) begin
                        state_q   <= StStart;
                        bit_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (vote_tick) begin
                        state_q <= vote ? StIdle : StData;
                    end
                end
                StData: begin
                    if (vote_tick) begin
                        shift_q   <= {vote, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef CSOC_UART_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef CSOC_UART_PARITY_EN
                StParity: begin
                    if (vote_tick) begin
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (vote_tick) begin
                        if (!vote) begin
                            ferr_q  <= 1'b1;
                            perr_q  <= stop_perr;
                            state_q <= StBreak;
                        end else begin
                            state_q <= StIdle;
                            if (stop_perr) begin
                                perr_q <= 1'b1;
                            end else if (valid_q && !ready_i) begin
                                ovr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_csoc_uart_rx.sv
// Self-checking bench for csoc_uart_rx at default parameters (224 clk per bit).
module tb_csoc_uart_rx;

    localparam int BitClk = 224;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

    always #20 clk = ~clk;

    csoc_uart_rx dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx           (rx),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int n_deliv = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic valid_prev = 1'b0, hs_prev = 1'b0;

    // Scoreboard: a new byte appears when valid rises or stays up after a handshake.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (frame_err_o)  n_ferr++;
        if (parity_err_o) n_perr++;
        if (overrun_o)    n_ovr++;
        if (valid_o && (!valid_prev || hs_prev)) begin
            n_checks++;
            n_deliv++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL delivery: got byte %02h, expected none", data_o);
            end else begin
                exp_b = exp_q.pop_front();
                if (data_o !== exp_b) begin
                    n_errors++;
                    $display("FAIL delivery: got %02h, expected %02h", data_o, exp_b);
                end
            end
        end
        hs_prev    = valid_o && ready_i;
        valid_prev = valid_o;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        cycles(BitClk);
    endtask

    // Start + 8 data LSB first (+ even parity, optionally inverted); stop bit is separate.
    task automatic send_body(input logic [7:0] b, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CSOC_UART_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) drive_bit(1'b1);
`endif
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_body(b, 1'b0);
        drive_bit(1'b1);
    endtask

    task automatic wait_deliv(input int target, input string name);
        int k = 0;
        while (n_deliv < target && k < 4 * BitClk) begin
            cycles(1);
            k++;
        end
        n_checks++;
        if (n_deliv < target) begin
            n_errors++;
            $display("FAIL %s: deliveries %0d, required %0d (timeout)", name, n_deliv, target);
        end
    endtask

    task automatic pulse_ready();
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx = 1'b1; ready_i = 1'b0;
        cycles(5);
        n_checks += 4;
        if (data_o !== 8'h00) begin n_errors++; $display("FAIL reset data: %02h vs 00", data_o); end
        if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset valid: %b vs 0", valid_o); end
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset busy: %b vs 0", busy_o); end
        if ({frame_err_o, parity_err_o, overrun_o} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset errs: %b vs 000", {frame_err_o, parity_err_o, overrun_o});
        end
        rstn = 1'b1;
        cycles(BitClk);
    endtask

    task automatic test_basic();
        int base = n_deliv;
        exp_q.push_back(8'h55);
        send_frame(8'h55);
        wait_deliv(base + 1, "basic");
        cycles(100);
        n_checks += 2;
        if (valid_o !== 1'b1) begin n_errors++; $display("FAIL basic hold valid: %b vs 1", valid_o); end
        if (data_o !== 8'h55) begin n_errors++; $display("FAIL basic hold data: %02h vs 55", data_o); end
        pulse_ready();
        n_checks += 2;
        if (valid_o !== 1'b0) begin n_errors++; $display("FAIL basic accept valid: %b vs 0", valid_o); end
        if (data_o !== 8'h55) begin n_errors++; $display("FAIL basic accept data: %02h vs 55", data_o); end
    endtask

    task automatic test_glitch();
        int d0 = n_deliv, f0 = n_ferr, p0 = n_perr;
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(8);
        n_checks++;
        if (busy_o !== 1'b1) begin n_errors++; $display("FAIL glitch busy: %b vs 1", busy_o); end
        cycles(2 * BitClk);
        n_checks += 3;
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch idle: busy %b vs 0", busy_o); end
        if (n_deliv !== d0) begin n_errors++; $display("FAIL glitch deliv: %0d vs %0d", n_deliv, d0); end
        if (n_ferr + n_perr !== f0 + p0) begin
            n_errors++;
            $display("FAIL glitch errs: %0d vs %0d", n_ferr + n_perr, f0 + p0);
        end
    endtask

    task automatic test_frame_err();
        int d0 = n_deliv, f0 = n_ferr;
        send_body(8'hA5, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        n_checks += 3;
        if (busy_o !== 1'b1) begin n_errors++; $display("FAIL ferr busy: %b vs 1", busy_o); end
        if (n_ferr !== f0 + 1) begin n_errors++; $display("FAIL ferr pulses: %0d vs %0d", n_ferr - f0, 1); end
        if (n_deliv !== d0) begin n_errors++; $display("FAIL ferr deliv: %0d vs %0d", n_deliv, d0); end
        rx = 1'b1;
        cycles(10);
        n_checks++;
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ferr release busy: %b vs 0", busy_o); end
        cycles(BitClk);
    endtask

    task automatic test_back_to_back();
        int base = n_deliv, o0 = n_ovr;
        exp_q.push_back(8'h12);
        send_frame(8'h12);
        send_frame(8'h34);
        cycles(20);
        n_checks += 4;
        if (n_ovr !== o0 + 1) begin n_errors++; $display("FAIL overrun pulses: %0d vs 1", n_ovr - o0); end
        if (data_o !== 8'h12) begin n_errors++; $display("FAIL overrun data: %02h vs 12", data_o); end
        if (valid_o !== 1'b1) begin n_errors++; $display("FAIL overrun valid: %b vs 1", valid_o); end
        if (n_deliv !== base + 1) begin n_errors++; $display("FAIL overrun deliv: %0d vs %0d", n_deliv, base + 1); end
        pulse_ready();
        n_checks++;
        if (valid_o !== 1'b0) begin n_errors++; $display("FAIL overrun accept valid: %b vs 0", valid_o); end
        base = n_deliv;
        o0 = n_ovr;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12);
        send_body(8'h34, 1'b0);
        ready_i = 1'b1;
        drive_bit(1'b1);
        ready_i = 1'b0;
        wait_deliv(base + 2, "b2b ready");
        n_checks += 2;
        if (n_ovr !== o0) begin n_errors++; $display("FAIL b2b overrun: %0d pulses vs 0", n_ovr - o0); end
        if (data_o !== 8'h34) begin n_errors++; $display("FAIL b2b data: %02h vs 34", data_o); end
    endtask

    task automatic test_reset_mid();
        int base, f0, p0;
        logic [7:0] b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        cycles(BitClk / 2);
        rstn = 1'b0;
        rx = 1'b1;
        cycles(5);
        n_checks += 3;
        if (data_o !== 8'h00) begin n_errors++; $display("FAIL midrst data: %02h vs 00", data_o); end
        if (valid_o !== 1'b0) begin n_errors++; $display("FAIL midrst valid: %b vs 0", valid_o); end
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL midrst busy: %b vs 0", busy_o); end
        rstn = 1'b1;
        cycles(BitClk);
        base = n_deliv; f0 = n_ferr; p0 = n_perr;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3);
        wait_deliv(base + 1, "midrst resend");
        n_checks += 2;
        if (data_o !== 8'hC3) begin n_errors++; $display("FAIL midrst resend data: %02h vs c3", data_o); end
        if (n_ferr + n_perr !== f0 + p0) begin
            n_errors++;
            $display("FAIL midrst errs: %0d vs %0d", n_ferr + n_perr, f0 + p0);
        end
        pulse_ready();
    endtask

`ifdef CSOC_UART_PARITY_EN
    task automatic test_parity();
        int base = n_deliv, p0 = n_perr;
        send_body(8'h07, 1'b1);
        drive_bit(1'b1);
        n_checks += 3;
        if (n_perr !== p0 + 1) begin n_errors++; $display("FAIL parity pulses: %0d vs 1", n_perr - p0); end
        if (valid_o !== 1'b0) begin n_errors++; $display("FAIL parity valid: %b vs 0", valid_o); end
        if (n_deliv !== base) begin n_errors++; $display("FAIL parity deliv: %0d vs %0d", n_deliv, base); end
        exp_q.push_back(8'h07);
        send_frame(8'h07);
        wait_deliv(base + 1, "parity good");
        n_checks++;
        if (data_o !== 8'h07) begin n_errors++; $display("FAIL parity good data: %02h vs 07", data_o); end
        pulse_ready();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef CSOC_UART_PARITY_EN
        test_parity();
`endif
        cycles(10);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d bytes pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
